mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Sequencer directly upstream and downstream of the 4:1 mux (`mux`: i[3:0], s[1:0], o).
- Drives the mux select through channels 0..3, holding each for a programmable dwell time.
- Samples the mux output at the end of each dwell and reassembles the four sampled bits into one captured word.
- Used to scan a 4-bit input bus through the single-bit mux path, either on demand or continuously.

Parameters:
- DWELL, 4, clock cycles the select is held per channel (legal range 1..255); the sample is taken on the last cycle.
- NCH, 4, number of channels scanned; fixed to match the mux width.
- SELW, 2, select width; equals clog2(NCH).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request a scan; accepted only in IDLE
- abort  in  1  terminate the current scan; highest priority after reset
- mux_o  in  1  output of the downstream mux (its o)
- sel  out  SELW  select to the mux (drives its s); registered
- busy  out  1  high in SETTLE and DONE
- done  out  1  one-cycle pulse when word is updated
- word  out  NCH  captured word; bit k is the value sampled while sel==k

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n). When rst_n=0 at a clock edge: state=IDLE, sel=0, cnt=0, busy=0, done=0, word=0, capture register=0. This applies mid-scan as well; no done is produced.
- Internal state: FSM {IDLE, SETTLE, DONE}, dwell counter cnt (width max(1,clog2(DWELL))), capture register cap[NCH-1:0].
- IDLE:
  - sel=0.
  - If start=1 and abort=0: go to SETTLE with cnt=0, sel=0.
  - Otherwise stay in IDLE.
- SETTLE:
  - Each cycle: cnt increments.
  - When cnt==DWELL-1: cap[sel] takes mux_o.
    - If sel==NCH-1: word takes {mux_o, cap[NCH-2:0]} on that same edge, and state goes to DONE.
    - Else: sel increments, cnt returns to 0.
- DONE: lasts one cycle; done=1. Next state is IDLE (see Optional Feature).
- Latency:
  - Start is sampled at edge E0.
  - Bit k is sampled at edge E0+(k+1)*DWELL.
  - word is valid and done=1 in the cycle after edge E0+NCH*DWELL (the 17th cycle after E0 for DWELL=4).
- start in SETTLE or DONE is ignored, not queued.
- abort=1 in SETTLE or DONE at an edge:
  - state goes to IDLE, sel=0, cnt=0, done=0.
  - word keeps its previous value; cap is discarded.
- start and abort both high in IDLE: stay in IDLE.
- DWELL=1: sel changes every cycle, and each sample is taken on the single cycle the select is held. The mux is combinational, so this is legal.
- word only changes at a completed scan and at reset. Partial scans are never visible on word.

Optional Feature:
- Macro: MUX_SCAN_CONT_EN.
- Defined (continuous mode):
  - DONE goes directly to SETTLE with sel=0, cnt=0.
  - Scans repeat back-to-back with period NCH*DWELL+1 cycles.
  - done pulses once per scan; busy stays high until abort or reset.
  - start is only needed for the first scan.
- Undefined: DONE goes to IDLE; one scan per start.

Decomposition:
- Shared package/header mux_scan_pkg:
  - state encodings ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_DONE=2'd2;
  - NCH and SELW constants;
  - the counter-width function.
- One natural sub-module: dwell_timer. It holds the cnt register, clear input and terminal-count output (cnt==DWELL-1), is parameterised by DWELL, and uses the same synchronous active-low reset.

Test Plan:
- Basic scan: DWELL=4, mux i=4'b1010, start pulse at E0 -> sel goes 0,1,2,3 for 4 cycles each; done=1 for one cycle after E0+16; word=4'b1010; busy low afterwards.
- Single-bit walk: i=4'b0001, then 4'b0010, 4'b0100, 4'b1000 across four scans -> word matches i each time; no other bits set.
- Abort mid-scan: word=4'b1010 from the prior scan; new scan with i=4'b0101, abort at E0+9 -> IDLE, sel=0, no done, word stays 4'b1010.
- Reset mid-scan: rst_n=0 for 1 cycle at E0+6 -> every output 0 on the next cycle, no done; a following start scans normally.
- Ignored start and minimum dwell: start held high throughout a DWELL=4 scan -> exactly one done per scan; with DWELL=1 and i=4'b1100 -> done after E0+4, word=4'b1100.
- MUX_SCAN_CONT_EN defined: single start, i changed from 4'b0011 to 4'b1001 between scans -> done pulses every 17 cycles; word=4'b0011 then 4'b1001; abort stops scanning.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared state encodings, channel constants and counter-width helper for mux_scan_ctrl
package mux_scan_pkg;

    localparam int NCH  = 4;
    localparam int SELW = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic int cnt_width(input int dwell);
        return (dwell <= 1) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - dwell counter with synchronous clear and terminal count at DWELL-1
module dwell_timer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tc_o
);

    localparam int CW = cnt_width(DWELL);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = clr_i ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CW'(DWELL - 1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - scans a 4:1 mux select and reassembles sampled bits; MUX_SCAN_CONT_EN enables back-to-back scans
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            mux_o,
    output logic [SELW-1:0] sel,
    output logic            busy,
    output logic            done,
    output logic [NCH-1:0]  word
);

    state_e          state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [NCH-1:0]  cap_q, cap_d;
    logic [NCH-1:0]  word_q, word_d;
    logic            cnt_clr;
    logic            tc;
    logic            last_ch;

    dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .tc_o  (tc)
    );

    assign last_ch = (sel_q == SELW'(NCH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cap_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cap_q   <= cap_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort) state_d = ST_IDLE;
                else if (tc && last_ch) state_d = ST_DONE;
            end
            ST_DONE: begin
`ifdef MUX_SCAN_CONT_EN
                state_d = abort ? ST_IDLE : ST_SETTLE;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter only runs while settling; every other state (and each channel boundary) restarts it.
    always_comb begin
        sel_d   = sel_q;
        cap_d   = cap_q;
        word_d  = word_q;
        cnt_clr = 1'b1;
        if (state_q == ST_SETTLE && !abort) begin
            cnt_clr = tc;
            if (tc) begin
                cap_d[sel_q] = mux_o;
                if (last_ch) begin
                    word_d = {mux_o, cap_q[NCH-2:0]};
                    sel_d  = '0;
                end else begin
                    sel_d  = sel_q + SELW'(1);
                end
            end
        end else begin
            sel_d = '0;
            if (state_q != ST_SETTLE || abort) cap_d = '0;
        end
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
        sel  = sel_q;
        word = word_q;
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl with DWELL=4 and DWELL=1 instances
module tb_mux_scan_ctrl;
    import mux_scan_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start4, abort4, start1, abort1;
    logic [3:0] i4, i1;
    logic       mux4, mux1;
    logic [1:0] sel4, sel1;
    logic       busy4, busy1, done4, done1;
    logic [3:0] word4, word1;

    assign mux4 = i4[sel4];
    assign mux1 = i1[sel1];

    mux_scan_ctrl #(.DWELL(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .mux_o(mux4),
        .sel(sel4), .busy(busy4), .done(done4), .word(word4)
    );

    mux_scan_ctrl #(.DWELL(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .mux_o(mux1),
        .sel(sel1), .busy(busy1), .done(done1), .word(word1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_i(input bit w1, input logic [3:0] v);
        if (w1) i1 = v; else i4 = v;
    endtask

    function automatic logic [3:0] get_i(input bit w1);
        return w1 ? i1 : i4;
    endfunction

    function automatic logic [3:0] get_out(input bit w1, input int what);
        case (what)
            0: return w1 ? 4'(sel1)  : 4'(sel4);
            1: return w1 ? 4'(busy1) : 4'(busy4);
            2: return w1 ? 4'(done1) : 4'(done4);
            default: return w1 ? word1 : word4;
        endcase
    endfunction

    // One full scan; expected word is rebuilt from the input value present at each sample edge.
    task automatic scan(input bit w1, input logic [3:0] pat, input bit jitter, input bit hold,
                        output logic [3:0] expw);
        int dw;
        int n;
        logic [3:0] hist [0:16];
        dw = w1 ? 1 : 4;
        n  = NCH * dw;
        set_i(w1, pat);
        if (w1) start1 = 1'b1; else start4 = 1'b1;
        tick();
        if (!hold) begin start1 = 1'b0; start4 = 1'b0; end
        for (int c = 1; c <= n; c++) begin
            chk("scan_sel",  get_out(w1, 0), 32'((c - 1) / dw));
            chk("scan_busy", get_out(w1, 1), 32'd1);
            chk("scan_nodone", get_out(w1, 2), 32'd0);
            if (jitter) set_i(w1, 4'($urandom_range(0, 15)));
            hist[c] = get_i(w1);
            tick();
        end
        for (int k = 0; k < NCH; k++) expw[k] = hist[(k + 1) * dw][k];
        chk("done_pulse", get_out(w1, 2), 32'd1);
        chk("done_busy",  get_out(w1, 1), 32'd1);
        chk("done_word",  get_out(w1, 3), 32'(expw));
        tick();
        chk("after_done",  get_out(w1, 2), 32'd0);
        chk("after_busy",  get_out(w1, 1), 32'd0);
        chk("after_sel",   get_out(w1, 0), 32'd0);
        start1 = 1'b0;
        start4 = 1'b0;
        tick();
        chk("idle_busy", get_out(w1, 1), 32'd0);
        chk("idle_word", get_out(w1, 3), 32'(expw));
    endtask

    typedef struct {
        bit         w1;
        logic [3:0] pat;
        bit         hold;
        logic [3:0] exp_word;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [3:0] w;
        int seen;
        int t;

        rst_n = 1'b0;
        start4 = 1'b0; abort4 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        i4 = 4'd0; i1 = 4'd0;
        tick(); tick();
        chk("rst_sel4", 32'(sel4), 0);
        chk("rst_busy4", 32'(busy4), 0);
        chk("rst_done4", 32'(done4), 0);
        chk("rst_word4", 32'(word4), 0);
        chk("rst_word1", 32'(word1), 0);
        rst_n = 1'b1;
        tick();

`ifdef MUX_SCAN_CONT_EN
        i4 = 4'b0011;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        t = 0;
        while (!done4 && t < 60) begin tick(); t++; end
        chk("cont_first_latency", 32'(t), 32'd16);
        chk("cont_word0", 32'(word4), 32'b0011);
        i4 = 4'b1001;
        t = 0;
        do begin tick(); t++; end while (!done4 && t < 60);
        chk("cont_period", 32'(t), 32'd17);
        chk("cont_word1", 32'(word4), 32'b1001);
        tick();
        chk("cont_busy", 32'(busy4), 32'd1);
        abort4 = 1'b1;
        tick();
        abort4 = 1'b0;
        chk("cont_abort_busy", 32'(busy4), 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin tick(); if (done4 || busy4) seen++; end
        chk("cont_stopped", 32'(seen), 32'd0);
`else
        vecs[0] = '{1'b0, 4'b1010, 1'b0, 4'b1010};
        vecs[1] = '{1'b0, 4'b0001, 1'b0, 4'b0001};
        vecs[2] = '{1'b0, 4'b0010, 1'b0, 4'b0010};
        vecs[3] = '{1'b0, 4'b0100, 1'b0, 4'b0100};
        vecs[4] = '{1'b0, 4'b1000, 1'b0, 4'b1000};
        vecs[5] = '{1'b0, 4'b0110, 1'b1, 4'b0110};
        vecs[6] = '{1'b1, 4'b1100, 1'b0, 4'b1100};
        vecs[7] = '{1'b0, 4'b1010, 1'b1, 4'b1010};
        for (int v = 0; v < 8; v++) begin
            scan(vecs[v].w1, vecs[v].pat, 1'b0, vecs[v].hold, w);
            chk("vec_word", 32'(w), 32'(vecs[v].exp_word));
        end

        for (int r = 0; r < 6; r++) begin
            scan(r[0], 4'($urandom_range(0, 15)), 1'b1, 1'($urandom_range(0, 1)), w);
        end
        scan(1'b0, 4'b1010, 1'b0, 1'b0, w);

        // abort at E0+9 must leave the previous word untouched
        i4 = 4'b0101;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int c = 1; c <= 8; c++) tick();
        abort4 = 1'b1;
        tick();
        abort4 = 1'b0;
        chk("abort_busy", 32'(busy4), 0);
        chk("abort_sel",  32'(sel4), 0);
        chk("abort_done", 32'(done4), 0);
        chk("abort_word", 32'(word4), 32'b1010);
        seen = 0;
        for (int c = 0; c < 20; c++) begin tick(); if (done4 || busy4) seen++; end
        chk("abort_quiet", 32'(seen), 0);
        chk("abort_word_kept", 32'(word4), 32'b1010);

        // reset at E0+6 clears everything and produces no done
        i4 = 4'b1111;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int c = 1; c <= 5; c++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rstmid_sel",  32'(sel4), 0);
        chk("rstmid_busy", 32'(busy4), 0);
        chk("rstmid_done", 32'(done4), 0);
        chk("rstmid_word", 32'(word4), 0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin tick(); if (done4) seen++; end
        chk("rstmid_nodone", 32'(seen), 0);
        scan(1'b0, 4'b0111, 1'b0, 1'b0, w);
        chk("rstmid_rescan", 32'(w), 32'b0111);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
